board_scan_renderer: RTL and testbench

Sequencer that redraws the 8x8 Othello board one 12x12 cell at a time by driving the cell-plot helper stage directly downstream. On `start` it walks all 64 cells in row-major order. For each cell it:
- reads the cell's occupancy from the board RAM,
- presents pixel origin and picture select,
- pulses the plot request,
- holds all outputs stable until the helper's `plot` busy line has risen and fallen.

It sits between the game-logic board RAM and the plot helper feeding the VGA adapter.

---
 rtl/board_scan_renderer_if.sv | 26 ++
 rtl/board_scan_renderer.sv | 142 ++++++++++++++
 tb/tb_board_scan_renderer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_scan_renderer_if.sv
// board_scan_renderer_if: bundles the board RAM read port and the cell-plot helper
// port between the board scan sequencer (master) and its RAM/helper peers (slave).
//
// Handshake: master raises enable for exactly one cycle with x_in/y_in/select
// already stable. The helper answers by raising plot_busy while it draws and
// dropping it when done. Master holds x_in/y_in/select until plot_busy has
// risen and fallen. Board RAM returns board_data one cycle after board_addr.
interface board_scan_renderer_if;
  logic [5:0] board_addr;
  logic [1:0] board_data;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [1:0] select;
  logic       enable;
  logic       plot_busy;

  modport master (
    output board_addr, x_in, y_in, select, enable,
    input  board_data, plot_busy
  );

  modport slave (
    input  board_addr, x_in, y_in, select, enable,
    output board_data, plot_busy
  );
endinterface

// File: rtl/board_scan_renderer.sv
// board_scan_renderer: walks the 8x8 Othello board in row-major order, fetching
// each cell from board RAM and handing origin/picture to the cell-plot helper.
// Optional feature macro: BOARD_CURSOR_EN (cursor cell drawn with select=1).
module board_scan_renderer #(
  parameter int CELL_SIZE = 12,
  parameter int X_ORIGIN  = 32,
  parameter int Y_ORIGIN  = 12,
  parameter int WATCHDOG  = 7
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [2:0]                   cursor_row,
  input  logic [2:0]                   cursor_col,
  board_scan_renderer_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [2:0]                   dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    FIRE    = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5,
    NEXT    = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [5:0] index;
  logic [7:0] wd;
  logic [7:0] x_reg;
  logic [6:0] y_reg;
  logic [1:0] sel_reg;
  logic [7:0] x_calc;
  logic [6:0] y_calc;
  logic [1:0] sel_calc;
  logic       wd_expired;
  logic       last_cell;

  assign last_cell  = (index == 6'd63);
  assign wd_expired = (wd == 8'(WATCHDOG - 1));

  // Pixel origin of the current cell; both wrap at their port width.
  assign x_calc = 8'(X_ORIGIN) + ({5'd0, index[2:0]} * 8'(CELL_SIZE));
  assign y_calc = 7'(Y_ORIGIN) + ({4'd0, index[5:3]} * 7'(CELL_SIZE));

`ifdef BOARD_CURSOR_EN
  logic cursor_hit;
  assign cursor_hit = ({cursor_row, cursor_col} == index);
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_row, cursor_col};
`endif

  // Picture select from occupancy, with the cursor overriding when enabled.
  always_comb begin
    sel_calc = 2'd0;
    case (bus.board_data)
      2'b01:   sel_calc = 2'd2;
      2'b10:   sel_calc = 2'd3;
      default: sel_calc = 2'd0;
    endcase
`ifdef BOARD_CURSOR_EN
    if (cursor_hit) sel_calc = 2'd1;
`endif
  end

  // State register; reset returns to IDLE at once so enable drops asynchronously.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = FIRE;
      FIRE:    state_nx = WAIT_HI;
      WAIT_HI: begin
        if (bus.plot_busy)   state_nx = WAIT_LO;
        else if (wd_expired) state_nx = NEXT;
      end
      WAIT_LO: if (!bus.plot_busy) state_nx = NEXT;
      NEXT:    state_nx = last_cell ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.enable     = (state == FIRE);
  assign busy           = (state != IDLE);
  assign bus.board_addr = index;
  assign bus.x_in       = x_reg;
  assign bus.y_in       = y_reg;
  assign bus.select     = sel_reg;
  assign dbg_state      = state;

  // Datapath: cell index, latched plot outputs, watchdog and frame flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      index   <= 6'd0;
      wd      <= 8'd0;
      x_reg   <= 8'd0;
      y_reg   <= 7'd0;
      sel_reg <= 2'd0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done <= (state == NEXT) && last_cell;
      case (state)
        IDLE: begin
          if (start) begin
            index   <= 6'd0;
            timeout <= 1'b0;
          end
        end
        LOAD: begin
          x_reg   <= x_calc;
          y_reg   <= y_calc;
          sel_reg <= sel_calc;
        end
        FIRE: wd <= 8'd0;
        WAIT_HI: begin
          if (!bus.plot_busy) begin
            if (wd_expired) timeout <= 1'b1;
            else            wd <= wd + 8'd1;
          end
        end
        NEXT: if (!last_cell) index <= index + 6'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_scan_renderer.sv
// tb_board_scan_renderer: drives full board redraws against a board RAM model and
// a cell-plot helper model, scoring every plot request against expected cells.
module tb_board_scan_renderer;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [2:0] cursor_row;
  logic [2:0] cursor_col;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [2:0] dbg_state;

  board_scan_renderer_if bus();

  board_scan_renderer dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- board RAM and helper models ----------------
  logic [1:0] mem [64];
  int         helper_mode;   // 1: normal helper, 0: never raises plot_busy
  int         hcnt;
  localparam int HELPER_BUSY = 145;

  always @(posedge clock) bus.board_data <= mem[bus.board_addr];

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hcnt          <= 0;
      bus.plot_busy <= 1'b0;
    end else if (helper_mode == 1 && bus.enable && hcnt == 0) begin
      hcnt          <= HELPER_BUSY;
      bus.plot_busy <= 1'b1;
    end else if (hcnt > 0) begin
      hcnt          <= hcnt - 1;
      bus.plot_busy <= (hcnt > 1);
    end
  end

  // ---------------- scoreboard ----------------
  int checks;
  int failures;
  logic [16:0] exp_q[$];   // {x_in, y_in, select}
  int start_cyc;
  int pulses;
  int first_en;
  int done_count;
  int done_rel;
  logic done_busy;
  logic done_timeout;

  function automatic logic [1:0] model_sel(input int idx);
    logic [1:0] s;
    case (mem[idx])
      2'b01:   s = 2'd2;
      2'b10:   s = 2'd3;
      default: s = 2'd0;
    endcase
`ifdef BOARD_CURSOR_EN
    if (idx == (int'(cursor_row) * 8 + int'(cursor_col))) s = 2'd1;
`endif
    return s;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < 64; i++) begin
      logic [7:0] ex;
      logic [6:0] ey;
      ex = 8'(32 + (i % 8) * 12);
      ey = 7'(12 + (i / 8) * 12);
      exp_q.push_back({ex, ey, model_sel(i)});
    end
  endtask

  // Output monitor: pops one expected cell per plot request.
  always @(negedge clock) begin
    if (resetn) begin
      if (bus.enable) begin
        pulses++;
        if (first_en < 0) first_en = cyc - start_cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_enable: got enable with empty expected queue at cycle %0d", cyc);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if ({bus.x_in, bus.y_in, bus.select} !== e)
          begin
            failures++;
            $display("FAIL cell_plot #%0d: x=%0d y=%0d sel=%0d, expected x=%0d y=%0d sel=%0d",
                     pulses - 1, bus.x_in, bus.y_in, bus.select, e[16:9], e[8:2], e[1:0]);
          end
        end
      end
      if (done) begin
        done_count++;
        done_rel     = cyc - start_cyc;
        done_busy    = busy;
        done_timeout = timeout;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame();
    @(negedge clock);
    push_frame();
    pulses   = 0;
    first_en = -1;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (done_count != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({busy, done, timeout, bus.enable} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: busy/done/timeout/enable=%b expected 0000",
               {busy, done, timeout, bus.enable});
    end
    checks++;
    if ({bus.x_in, bus.y_in, bus.select, bus.board_addr} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: x=%0d y=%0d sel=%0d addr=%0d expected all 0",
               bus.x_in, bus.y_in, bus.select, bus.board_addr);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: state=%0d expected 0", dbg_state);
    end
  endtask

  task automatic test_empty_frame();
    bit ok;
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
    cursor_row  = 3'd0;
    cursor_col  = 3'd0;
    helper_mode = 1;
    start_frame();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise: busy=%b expected 1 the cycle after start", busy);
    end
    wait_done(12000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL empty_done_timeout: no done within 12000 cycles");
    end
    checks++;
    if (done_rel !== 9600) begin
      failures++;
      $display("FAIL empty_frame_len: done at %0d cycles, expected 9600", done_rel);
    end
    checks++;
    if (first_en !== 2) begin
      failures++;
      $display("FAIL enable_latency: first enable at +%0d, expected +2 (sampled at N+3)", first_en);
    end
    checks++;
    if (pulses !== 64 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL empty_pulses: pulses=%0d left=%0d expected 64 and 0", pulses, exp_q.size());
    end
    checks++;
    if (done_busy !== 1'b0 || done_timeout !== 1'b0) begin
      failures++;
      $display("FAIL empty_done_flags: busy=%b timeout=%b expected 0 0", done_busy, done_timeout);
    end
    checks++;
    if (bus.x_in !== 8'd116 || bus.y_in !== 7'd96) begin
      failures++;
      $display("FAIL last_cell_hold: x=%0d y=%0d expected 116 96", bus.x_in, bus.y_in);
    end
  endtask

  task automatic test_board_pattern();
    bit ok;
    logic [1:0] want;
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
    mem[9]  = 2'b01;
    mem[63] = 2'b10;
    mem[5]  = 2'b11;
    mem[10] = 2'b10;
    mem[$urandom_range(20, 60)] = 2'($urandom_range(1, 3));
    cursor_row = 3'd7;
    cursor_col = 3'd7;
`ifdef BOARD_CURSOR_EN
    want = 2'd1;
`else
    want = 2'd3;
`endif
    start_frame();
    wait_done(12000, ok);
    checks++;
    if (!ok || pulses !== 64 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL pattern_frame: done=%b pulses=%0d left=%0d expected 1 64 0", ok, pulses, exp_q.size());
    end
    checks++;
    if (bus.select !== want) begin
      failures++;
      $display("FAIL cell63_select: sel=%0d expected %0d", bus.select, want);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    helper_mode = 0;
    start_frame();
    wait_done(2000, ok);
    checks++;
    if (!ok || done_rel !== 704) begin
      failures++;
      $display("FAIL watchdog_frame_len: done=%b at %0d cycles, expected 704", ok, done_rel);
    end
    checks++;
    if (done_timeout !== 1'b1 || pulses !== 64 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL watchdog_result: timeout=%b pulses=%0d left=%0d expected 1 64 0",
               done_timeout, pulses, exp_q.size());
    end
    repeat (3) @(negedge clock);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: timeout=%b expected 1 after frame", timeout);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int dc0;
    helper_mode = 1;
    dc0 = done_count;
    start_frame();
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: timeout=%b expected 0 after new start", timeout);
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      start = ((cyc - start_cyc) == 5 || (cyc - start_cyc) == 500);
    end
    @(negedge clock);
    start = 1'b0;
    wait_done(12000, ok);
    repeat (300) @(negedge clock);
    checks++;
    if (!ok || done_rel !== 9600 || (done_count - dc0) !== 1) begin
      failures++;
      $display("FAIL start_ignored: done=%b at %0d count=%0d expected 1 at 9600 count 1",
               ok, done_rel, done_count - dc0);
    end
    checks++;
    if (pulses !== 64 || busy !== 1'b0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL start_ignored_pulses: pulses=%0d busy=%b left=%0d expected 64 0 0",
               pulses, busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    int dc0;
    helper_mode = 1;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (bus.board_addr == 6'd20 && dbg_state == 3'd5) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_cell20: never saw WAIT_LO of cell 20 (addr=%0d state=%0d)",
               bus.board_addr, dbg_state);
    end
    dc0 = done_count;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({bus.enable, busy, done, timeout, bus.x_in, bus.y_in, bus.select, bus.board_addr} !== 27'd0) begin
      failures++;
      $display("FAIL async_reset: en=%b busy=%b done=%b to=%b x=%0d y=%0d sel=%0d addr=%0d expected all 0",
               bus.enable, busy, done, timeout, bus.x_in, bus.y_in, bus.select, bus.board_addr);
    end
    exp_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (done_count !== dc0 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_abort: extra done=%0d state=%0d expected 0 and 0",
               done_count - dc0, dbg_state);
    end
    start_frame();
    wait_done(12000, ok);
    checks++;
    if (!ok || done_rel !== 9600 || pulses !== 64 || exp_q.size() !== 0 || first_en !== 2) begin
      failures++;
      $display("FAIL redraw_after_reset: done=%b at %0d pulses=%0d left=%0d first_en=%0d expected 1 9600 64 0 2",
               ok, done_rel, pulses, exp_q.size(), first_en);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    start_cyc   = 0;
    pulses      = 0;
    first_en    = -1;
    done_count  = 0;
    done_rel    = 0;
    helper_mode = 1;
    resetn      = 1'b0;
    start       = 1'b0;
    cursor_row  = 3'd0;
    cursor_col  = 3'd0;
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
    repeat (3) @(negedge clock);
    test_reset();
    resetn = 1'b1;
    @(negedge clock);
    test_reset();
    test_empty_frame();
    test_board_pattern();
    test_watchdog();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
